// File: rtl/reward_timer_pkg.sv
// reward_timer_pkg
// Shared definitions for the reward timer and the item-information renderer:
// item-type encodings, the default reward lifetime, the timer FSM state
// encoding and the display colours used for each reward.
package reward_timer_pkg;

    typedef enum logic [1:0] {
        ITEM_INVINCIBLE = 2'd0,
        ITEM_FROZEN     = 2'd1,
        ITEM_FASTER     = 2'd2,
        ITEM_LASER      = 2'd3
    } item_e;

    localparam int DURATION_DEFAULT = 30;
    localparam int ITEM_CNT_W       = 10;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    // 12-bit RGB colours shared with the item-information renderer
    localparam logic [11:0] COLOR_INVINCIBLE = 12'hFF0;
    localparam logic [11:0] COLOR_FROZEN     = 12'h0FF;
    localparam logic [11:0] COLOR_FASTER     = 12'h0F0;
    localparam logic [11:0] COLOR_LASER      = 12'hF00;
    localparam logic [11:0] COLOR_BAR_BG     = 12'h333;

    // Flag vector order: [0]=invincible [1]=frozen [2]=faster [3]=laser
    function automatic logic [3:0] item_onehot(input item_e t);
        return 4'b0001 << t;
    endfunction

endpackage

// File: rtl/reward_timer_sec_tick_gen.sv
// sec_tick_gen
// One-second prescaler. Counts 0..TICK_DIV-1 and flags tick in the cycle
// whose edge wraps the count back to 0.
// Ports:
//   clk   - system clock (rising edge)
//   rst_n - asynchronous active-low reset
//   clear - force the count to 0 on the next edge (wins over hold)
//   hold  - freeze the count; no tick while held
//   tick  - high in the wrap cycle
module sec_tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap;

    assign wrap = (cnt_q == LAST);
    assign tick = !clear && !hold && wrap;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/reward_timer.sv
// reward_timer
// Tracks the active power-up reward: which item is held, how many seconds
// have elapsed, and a one-cycle pulse when the reward times out.
// Ports:
//   clk, rst_n                 - clock, asynchronous active-low reset
//   enable_reward              - feature enable; low forces idle
//   pause                      - freeze timer, flags and item_cnt
//   pickup_valid, pickup_type  - one-cycle pickup pulse and item type
//   item_cnt                   - seconds elapsed in current reward
//   item_invincible/frozen/faster/laser - registered one-hot reward flags
//   item_expire                - one-cycle timeout pulse
module reward_timer
    import reward_timer_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000,
    parameter int DURATION = DURATION_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable_reward,
    input  logic                  pause,
    input  logic                  pickup_valid,
    input  logic [1:0]            pickup_type,
    output logic [ITEM_CNT_W-1:0] item_cnt,
    output logic                  item_invincible,
    output logic                  item_frozen,
    output logic                  item_faster,
    output logic                  item_laser,
    output logic                  item_expire
);

    localparam logic [ITEM_CNT_W-1:0] CNT_LAST = ITEM_CNT_W'(DURATION - 1);

    state_e                state_q, state_d;
    logic [3:0]            flags_q, flags_d;
    logic [ITEM_CNT_W-1:0] cnt_q, cnt_d;
    logic                  expire_q, expire_d;

    logic accept;
    logic presc_clear;
    logic sec_tick;

    assign accept = enable_reward && pickup_valid;

    // Prescaler sits at 0 whenever idle, disabled, or restarting on a pickup
    assign presc_clear = !enable_reward || accept || (state_q == ST_IDLE);

    sec_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_sec_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (presc_clear),
        .hold  (pause),
        .tick  (sec_tick)
    );

    // Priority: disable > pickup > tick
    always_comb begin
        state_d  = state_q;
        flags_d  = flags_q;
        cnt_d    = cnt_q;
        expire_d = 1'b0;
        if (!enable_reward) begin
            state_d = ST_IDLE;
            flags_d = '0;
            cnt_d   = '0;
        end else if (accept) begin
            state_d = ST_ACTIVE;
            flags_d = item_onehot(item_e'(pickup_type));
            cnt_d   = '0;
        end else if (state_q == ST_ACTIVE && sec_tick) begin
            if (cnt_q == CNT_LAST) begin
                state_d  = ST_IDLE;
                flags_d  = '0;
                cnt_d    = '0;
                expire_d = 1'b1;
            end else begin
                cnt_d = cnt_q + ITEM_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            flags_q  <= '0;
            cnt_q    <= '0;
            expire_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            cnt_q    <= cnt_d;
            expire_q <= expire_d;
        end
    end

    assign item_cnt        = cnt_q;
    assign item_invincible = flags_q[0];
    assign item_frozen     = flags_q[1];
    assign item_faster     = flags_q[2];
    assign item_laser      = flags_q[3];
    assign item_expire     = expire_q;

endmodule

// File: doc/reward_timer.md
REWARD_TIMER -- requirements
Module: reward_timer

Interface
REQ-001 Parameter TICK_DIV, default 100_000_000: clk cycles per one-second tick; minimum 2.
REQ-002 Parameter DURATION, default 30: reward lifetime in seconds; maximum 1023.
REQ-003 clk  input  1  single system clock; all logic is rising-edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 enable_reward  input  1  reward feature enable; low forces idle and blocks pickups.
REQ-006 pause  input  1  high freezes the timer; state, flags and item_cnt are held.
REQ-007 pickup_valid  input  1  one-cycle pulse meaning the player tank collected an item.
REQ-008 pickup_type  input  2  item type: 0=invincible, 1=frozen, 2=faster, 3=laser; sampled only when pickup_valid is high.
REQ-009 item_cnt  output  10  seconds elapsed in the current reward, 0..DURATION-1; downstream draws the bar from DURATION minus item_cnt.
REQ-010 item_invincible, item_frozen, item_faster, item_laser  output  1 each  active reward flags; at most one is high at any time.
REQ-011 item_expire  output  1  one-cycle pulse when a reward times out.

Function
REQ-012 The block SHALL use a two-state FSM: IDLE and ACTIVE.
REQ-013 In IDLE, all flags SHALL be low, item_cnt SHALL be 0, and the prescaler SHALL be held at 0.
REQ-014 A pickup is accepted when pickup_valid=1 and enable_reward=1; pause does not block acceptance.
- From IDLE: the FSM goes to ACTIVE.
- In both states: exactly the flag selected by pickup_type is set and all others are cleared, item_cnt is set to 0, and the prescaler is set to 0.
REQ-015 Latency from pickup to output: flags and item_cnt SHALL update on the clock edge that samples pickup_valid, so they are visible the next cycle.
REQ-016 In ACTIVE with pause=0, the prescaler SHALL count 0..TICK_DIV-1 and assert an internal sec_tick in the cycle where it wraps to 0.
REQ-017 When sec_tick fires and item_cnt < DURATION-1, item_cnt SHALL increment by 1.
REQ-018 When sec_tick fires and item_cnt = DURATION-1, the next edge SHALL do all of the following:
- clear all flags;
- set item_cnt to 0;
- pulse item_expire high for exactly one cycle;
- move the FSM to IDLE.
REQ-019 If an accepted pickup coincides with sec_tick (including the expiry tick), the pickup SHALL win: the new reward restarts, no increment occurs, and no item_expire pulse is produced.
REQ-020 If pause=1, the prescaler and item_cnt SHALL hold their values and no sec_tick is generated.
REQ-021 If enable_reward=0, the block SHALL return to IDLE on the next edge: flags cleared, item_cnt=0, no item_expire pulse; this takes priority over pickup and tick.
REQ-022 Counter widths SHALL be ceil(log2(TICK_DIV)) for the prescaler and 10 bits for item_cnt.
- item_cnt never wraps.
- item_cnt never exceeds DURATION-1.
REQ-023 The flag outputs SHALL be registered and one-hot or all-zero; no combinational path runs from any input to any output.

Reset
REQ-024 Asserting rst_n=0 SHALL immediately force the FSM to IDLE, clear the prescaler, set item_cnt=0, and drive all flags and item_expire to 0.
REQ-025 Reset asserted mid-reward SHALL abandon the reward with no item_expire pulse.
REQ-026 Deassertion of rst_n SHALL be synchronised externally; the first active edge after release behaves as IDLE.

Structure
REQ-027 A shared package SHALL hold:
- the item-type encodings (ITEM_INVINCIBLE..ITEM_LASER);
- the DURATION default;
- the FSM state encoding;
- the display colour constants shared with the item-information renderer.
REQ-028 The prescaler SHALL be a sub-module, sec_tick_gen, with ports clk, rst_n, clear, hold, and tick.
REQ-029 All other logic stays in reward_timer.

Verification
REQ-030 With TICK_DIV=4 and DURATION=3: pickup type 3 -> item_laser=1 next cycle; item_cnt steps 0,1,2 at 4-cycle intervals; item_expire pulses exactly 12 cycles after the pickup edge; item_laser=0 afterwards.
REQ-031 Mid-reward swap: while item_frozen is active with item_cnt=1, pickup type 2 -> item_faster=1, item_frozen=0, item_cnt=0, full duration restarts, and no expire pulse between.
REQ-032 Pickup on the expiry tick cycle -> no item_expire pulse; the new flag is set with item_cnt=0.
REQ-033 pause held high for 10 cycles at item_cnt=1 -> item_cnt stays 1 and expiry is delayed by exactly 10 cycles.
REQ-034 enable_reward dropped at item_cnt=2 -> all flags 0 and item_cnt=0 next cycle, no expire pulse; a pickup while enable_reward=0 is ignored.
REQ-035 rst_n pulsed low asynchronously mid-reward -> outputs go to zero without waiting for a clock edge; no expire pulse after release.
